mem_copy_master: RTL and testbench

Word-copy DMA engine acting as an initiator on the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata). It drives the same bus that the system memory/peripheral responder serves, alternating single-word reads from a source region with full-word writes to a destination region. It sits beside the CPU behind a bus arbiter, or alone on the responder in standalone benches. Software-visible control is a start pulse plus source, destination and length, with busy, done and error status.

---
 rtl/mem_copy_master.sv | 121 ++++++++++++
 tb/tb_mem_copy_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// mem_copy_master: word-copy DMA initiator on the PicoRV32 native memory bus.
// Alternates one read from the source region with one full-word write to the destination region.
module mem_copy_master #(
   parameter int TIMEOUT = 256,
   parameter int LEN_W   = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [LEN_W-1:0] words_done,
   output logic             mem_valid,
   output logic             mem_instr,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_rdata
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
   state_t           state, state_n;
   logic [31:0]      src, src_n, dst, dst_n, data, data_n;
   logic [LEN_W-1:0] len, len_n, wd_n;
   logic [TW-1:0]    tcnt, tcnt_n;
   logic             valid_n, busy_n, done_n, error_n;
   // Address and strobe follow the state, so they hold still for as long as a request stalls.
   assign mem_instr = 1'b0;
   assign mem_addr  = (state == WR) ? dst : src;
   assign mem_wdata = data;
   assign mem_wstrb = (state == WR) ? 4'hF : 4'h0;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         src        <= '0;
         dst        <= '0;
         data       <= '0;
         len        <= '0;
         tcnt       <= '0;
         words_done <= '0;
         mem_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_n;
         src        <= src_n;
         dst        <= dst_n;
         data       <= data_n;
         len        <= len_n;
         tcnt       <= tcnt_n;
         words_done <= wd_n;
         mem_valid  <= valid_n;
         busy       <= busy_n;
         done       <= done_n;
         error      <= error_n;
      end
   end
   always_comb begin
      state_n = state;
      src_n   = src;
      dst_n   = dst;
      data_n  = data;
      len_n   = len;
      tcnt_n  = tcnt;
      wd_n    = words_done;
      valid_n = mem_valid;
      busy_n  = busy;
      done_n  = 1'b0;
      error_n = error;
      case (state)
         IDLE: if (start) begin
            src_n   = {src_addr[31:2], 2'b00};
            dst_n   = {dst_addr[31:2], 2'b00};
            len_n   = len_words;
            wd_n    = '0;
            error_n = 1'b0;
            tcnt_n  = '0;
            done_n  = (len_words == '0);
            busy_n  = (len_words != '0);
            valid_n = (len_words != '0);
            state_n = (len_words == '0) ? IDLE : RD;
         end
         RD, WR: begin
            // A dropped mem_valid here is the mandatory idle cycle after an acknowledge.
            if (!mem_valid) valid_n = 1'b1;
            else if (mem_ready) begin
               valid_n = 1'b0;
               tcnt_n  = '0;
               if (state == RD) begin
                  data_n  = mem_rdata;
                  src_n   = src + 32'd4;
                  state_n = WR;
               end else begin
                  dst_n   = dst + 32'd4;
                  wd_n    = words_done + 1'b1;
                  state_n = (wd_n == len) ? FIN : RD;
               end
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               valid_n = 1'b0;
               error_n = 1'b1;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               tcnt_n  = '0;
               state_n = IDLE;
            end else tcnt_n = tcnt + 1'b1;
         end
         FIN: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: directed bench for mem_copy_master with a latency-programmable responder.
// The responder maps byte address bits {9:8,5:2} onto a 64-word array.
module tb_mem_copy_master;
   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0, dst_addr = '0;
   logic [15:0] len_words = '0;
   logic        busy, done, error, mem_valid, mem_instr, mem_ready;
   logic [15:0] words_done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] tmem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;
   int          base_lat = 0, jit = 0, wait_cnt = 0;
   bit          rnd = 1'b0, blk_wr = 1'b0;
   int          tests = 0, fails = 0;
   int          acks = 0, dones = 0, vcyc = 0, bcyc = 0, proto_err = 0;
   logic [31:0] last_rd = '0;
   logic        p_valid, p_ready;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_wstrb;

   mem_copy_master #(.TIMEOUT(8), .LEN_W(16)) dut (
      .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len_words(len_words), .busy(busy), .done(done), .error(error), .words_done(words_done),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] ix(input logic [31:0] a);
      return {a[9:8], a[5:2]};
   endfunction

   assign mem_rdata = tmem[ix(mem_addr)];
   assign mem_ready = mem_valid && !(blk_wr && mem_wstrb == 4'hF) && wait_cnt >= base_lat + (rnd ? jit : 0);

   always @(posedge clk) begin
      if (pl_en) tmem[pl_idx] <= pl_data;
      else if (mem_valid && mem_ready && mem_wstrb == 4'hF) tmem[ix(mem_addr)] <= mem_wdata;
   end

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wait_cnt <= 0;
         jit      <= 0;
      end else if (!mem_valid || mem_ready) begin
         wait_cnt <= 0;
         if (mem_valid) jit <= int'($urandom_range(0, 3));
      end else wait_cnt <= wait_cnt + 1;
   end

   // Bus protocol monitor: stable request while stalled, one idle cycle after each acknowledge.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_valid <= 1'b0;
         p_ready <= 1'b0;
         p_addr  <= '0;
         p_wdata <= '0;
         p_wstrb <= '0;
      end else begin
         proto_err <= proto_err
            + int'(p_valid && !p_ready && mem_valid && (mem_addr != p_addr || mem_wdata != p_wdata || mem_wstrb != p_wstrb))
            + int'(p_valid && p_ready && mem_valid) + int'(mem_instr !== 1'b0);
         p_valid <= mem_valid;
         p_ready <= mem_ready;
         p_addr  <= mem_addr;
         p_wdata <= mem_wdata;
         p_wstrb <= mem_wstrb;
         if (mem_valid && mem_ready) acks <= acks + 1;
         if (mem_valid && mem_ready && mem_wstrb == 4'h0) last_rd <= mem_addr;
         if (done) dones <= dones + 1;
         if (mem_valid) vcyc <= vcyc + 1;
         if (busy) bcyc <= bcyc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input int i, input logic [31:0] v);
      pl_en   = 1'b1;
      pl_idx  = i[5:0];
      pl_data = v;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Pulses start and waits for done; cyc counts negedges from the edge that sampled start.
   task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, input bit mid,
                      output int cyc, output logic b1, output logic v1);
      @(negedge clk);
      src_addr  = s;
      dst_addr  = d;
      len_words = l;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      b1    = busy;
      v1    = mem_valid;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (mid && cyc == 4) begin
            src_addr  = 32'h100;
            dst_addr  = 32'h200;
            len_words = 16'd5;
            start     = 1'b1;
         end else start = 1'b0;
      end
      start = 1'b0;
      chk("done_seen", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int cyc, a0, d0, v0, b0;
      logic b1, v1;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
      chk("rst_addr_wd", mem_addr | {16'd0, words_done} | {28'd0, mem_wstrb} | {31'd0, mem_instr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      resetn = 1'b1;

      for (int i = 0; i < 4; i++) load(16 + i, 32'hA5A5_0001 + i);
      a0 = acks; d0 = dones;
      run(32'h100, 32'h200, 16'd4, 1'b0, cyc, b1, v1);
      chk("t1_cycles", cyc, 32'd17);
      chk("t1_busy_start", {31'd0, b1}, 32'd1);
      chk("t1_valid_start", {31'd0, v1}, 32'd1);
      chk("t1_busy_done", {31'd0, busy}, 32'd0);
      chk("t1_words", {16'd0, words_done}, 32'd4);
      chk("t1_error", {31'd0, error}, 32'd0);
      @(negedge clk);
      chk("t1_done_pulse", {31'd0, done}, 32'd0);
      chk("t1_acks", acks - a0, 32'd8);
      chk("t1_dones", dones - d0, 32'd1);
      for (int i = 0; i < 4; i++) chk("t1_mem", tmem[32 + i], 32'hA5A5_0001 + i);

      base_lat = 3; rnd = 1'b1;
      for (int i = 0; i < 16; i++) load(16 + i, 32'hC0DE_0000 + 3 * i);
      a0 = acks;
      run(32'h100, 32'h300, 16'd16, 1'b0, cyc, b1, v1);
      chk("t2_words", {16'd0, words_done}, 32'd16);
      chk("t2_error", {31'd0, error}, 32'd0);
      @(negedge clk);
      chk("t2_acks", acks - a0, 32'd32);
      for (int i = 0; i < 16; i++) chk("t2_mem", tmem[48 + i], 32'hC0DE_0000 + 3 * i);
      chk("t2_proto", proto_err, 32'd0);
      base_lat = 0; rnd = 1'b0;

      a0 = acks; v0 = vcyc; b0 = bcyc;
      run(32'h100, 32'h200, 16'd0, 1'b0, cyc, b1, v1);
      chk("t3_cycles", cyc, 32'd1);
      chk("t3_busy_start", {31'd0, b1}, 32'd0);
      chk("t3_valid_start", {31'd0, v1}, 32'd0);
      @(negedge clk);
      chk("t3_done_pulse", {31'd0, done}, 32'd0);
      chk("t3_valid_cycles", vcyc - v0, 32'd0);
      chk("t3_busy_cycles", bcyc - b0, 32'd0);
      chk("t3_acks", acks - a0, 32'd0);

      blk_wr = 1'b1;
      run(32'h100, 32'h240, 16'd2, 1'b0, cyc, b1, v1);
      chk("t4_cycles", cyc, 32'd11);
      chk("t4_error", {31'd0, error}, 32'd1);
      chk("t4_words", {16'd0, words_done}, 32'd0);
      chk("t4_valid", {31'd0, mem_valid}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("t4_error_hold", {31'd0, error}, 32'd1);
      blk_wr = 1'b0;
      run(32'h104, 32'h240, 16'd1, 1'b0, cyc, b1, v1);
      chk("t4b_cycles", cyc, 32'd5);
      chk("t4b_error", {31'd0, error}, 32'd0);
      chk("t4b_words", {16'd0, words_done}, 32'd1);
      chk("t4b_mem", tmem[32], 32'hC0DE_0003);

      load(63, 32'h5EED_0001);
      load(0, 32'h5EED_0002);
      a0 = acks;
      run(32'hFFFF_FFFF, 32'h0000_0223, 16'd2, 1'b1, cyc, b1, v1);
      chk("t5_cycles", cyc, 32'd9);
      chk("t5_words", {16'd0, words_done}, 32'd2);
      chk("t5_last_rd", last_rd, 32'd0);
      @(negedge clk);
      chk("t5_acks", acks - a0, 32'd4);
      chk("t5_mem0", tmem[40], 32'h5EED_0001);
      chk("t5_mem1", tmem[41], 32'h5EED_0002);

      blk_wr = 1'b1;
      @(negedge clk);
      src_addr = 32'h100; dst_addr = 32'h230; len_words = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t6_stalled", {27'd0, busy, mem_valid, mem_wstrb[3:1]}, {27'd0, 5'b11111});
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_valid", {31'd0, mem_valid}, 32'd0);
      chk("t6_flags", {29'd0, busy, done, error}, 32'd0);
      chk("t6_addr_wd", mem_addr | {16'd0, words_done} | {28'd0, mem_wstrb}, 32'd0);
      chk("t6_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      blk_wr = 1'b0;
      run(32'h100, 32'h230, 16'd3, 1'b0, cyc, b1, v1);
      chk("t6_cycles", cyc, 32'd13);
      chk("t6_words", {16'd0, words_done}, 32'd3);
      chk("t6_error", {31'd0, error}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("t6_mem", tmem[44 + i], 32'hC0DE_0000 + 3 * i);
      chk("final_proto", proto_err, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
